// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
//   Control stage feeding the TMR shift register (three copies plus voter).
//   It takes TX (parallel-in, serial-out) and RX (serial-in, parallel-out)
//   commands on a valid/ready interface. It drives the register's control
//   and data pins for one load cycle (TX only) and then exactly `width`
//   shift cycles. It pulses `done` at the end and returns RX words taken
//   from the voted parallel output.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous reset, active low
//   s_valid/s_ready   command handshake
//   s_cmd             0 = TX, 1 = RX
//   s_data            TX word (ignored for RX)
//   abort             synchronous cancel of an active LOAD/SHIFT
//   sdi               serial line in, used by RX
//   reg_enable        register enable
//   reg_load          register load strobe
//   reg_mode          register mode: 11 hold, 10 PISO, 00 SIPO
//   reg_parallel_in   register parallel data (data_q in LOAD only)
//   reg_serial_in     register serial data (sdi during RX shift)
//   reg_parallel_out  voted register contents
//   tx_bit_valid      voted serial_out carries a TX bit this cycle
//   busy              command in progress
//   done              one-cycle completion pulse
//   rx_valid          one-cycle pulse when rx_data has been updated
//   rx_data           last received word
module shift_reg_sequencer #(
  parameter  int width = 128,
  localparam int cw    = $clog2(width + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_cmd,
  input  logic [width-1:0] s_data,
  input  logic             abort,
  input  logic             sdi,
  output logic             reg_enable,
  output logic             reg_load,
  output logic [1:0]       reg_mode,
  output logic [width-1:0] reg_parallel_in,
  output logic             reg_serial_in,
  input  logic [width-1:0] reg_parallel_out,
  output logic             tx_bit_valid,
  output logic             busy,
  output logic             done,
  output logic             rx_valid,
  output logic [width-1:0] rx_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [cw-1:0] LAST_BIT = cw'(width - 1);
  localparam logic          CMD_RX   = 1'b1;

  state_t          state, state_nxt;
  logic [cw-1:0]   cnt, cnt_nxt;
  logic [width-1:0] data_q;
  logic            cmd_q;

  // State, counter and command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      cmd_q    <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (s_valid && s_ready) begin
        cmd_q  <= s_cmd;
        data_q <= s_data;
      end
      // The register holds in DONE, so parallel_out is the finished word.
      rx_valid <= (state == DONE) && (cmd_q == CMD_RX);
      if ((state == DONE) && (cmd_q == CMD_RX))
        rx_data <= reg_parallel_out;
    end
  end

  // Next-state and register control decode
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    busy            = 1'b1;
    s_ready         = 1'b0;
    reg_enable      = 1'b0;
    reg_load        = 1'b0;
    reg_mode        = 2'b11;
    reg_parallel_in = '0;
    reg_serial_in   = 1'b0;
    tx_bit_valid    = 1'b0;
    done            = 1'b0;
    unique case (state)
      IDLE: begin
        busy    = 1'b0;
        s_ready = 1'b1;
        if (s_valid) begin
          cnt_nxt   = '0;
          state_nxt = (s_cmd == CMD_RX) ? SHIFT : LOAD;
        end
      end
      LOAD: begin
        reg_enable      = 1'b1;
        reg_load        = 1'b1;
        reg_mode        = 2'b10;
        reg_parallel_in = data_q;
        state_nxt       = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        reg_enable = 1'b1;
        if (cmd_q == CMD_RX) begin
          reg_mode      = 2'b00;
          reg_serial_in = sdi;
        end else begin
          reg_mode     = 2'b10;
          tx_bit_valid = 1'b1;
        end
        cnt_nxt = cnt + 1'b1;
        if (abort)
          state_nxt = IDLE;
        else if (cnt == LAST_BIT)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
module tb_shift_reg_sequencer;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         s_cmd = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         abort = 1'b0;
  logic         sdi = 1'b0;
  logic         reg_enable, reg_load, reg_serial_in;
  logic [1:0]   reg_mode;
  logic [W-1:0] reg_parallel_in, reg_parallel_out;
  logic         tx_bit_valid, busy, done, rx_valid;
  logic [W-1:0] rx_data;

  shift_reg_sequencer #(.width(W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd),
    .s_data(s_data), .abort(abort), .sdi(sdi), .reg_enable(reg_enable),
    .reg_load(reg_load), .reg_mode(reg_mode), .reg_parallel_in(reg_parallel_in),
    .reg_serial_in(reg_serial_in), .reg_parallel_out(reg_parallel_out),
    .tx_bit_valid(tx_bit_valid), .busy(busy), .done(done), .rx_valid(rx_valid),
    .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream register: right shift, serial_out = bit 0,
  // serial_in enters at the MSB.
  logic [W-1:0] stub_q = '0;
  always @(posedge clk)
    if (reg_enable)
      case (reg_mode)
        2'b10:   stub_q <= reg_load ? reg_parallel_in : {1'b0, stub_q[W-1:1]};
        2'b00:   stub_q <= {reg_serial_in, stub_q[W-1:1]};
        default: stub_q <= stub_q;
      endcase
  assign reg_parallel_out = stub_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a command accepted in cycle T is described by its
  // offset from T. TX: offset 1 load, 2..W+1 shift, W+2 done.
  // RX: offset 1..W shift, W+1 done.
  bit           m_active = 0;
  bit           m_cmd = 0;
  int           m_off = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_rx_bits = '0;
  logic [W-1:0] m_rx_data = '0;
  bit           m_rx_valid = 0;
  int           m_last;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_off = 0; m_rx_data = '0; m_rx_valid = 0;
    end else begin
      m_rx_valid = 0;
      if (!m_active) begin
        if (s_valid) begin
          m_active = 1; m_cmd = s_cmd; m_data = s_data; m_off = 1;
        end
      end else begin
        m_last = m_cmd ? W + 1 : W + 2;
        if (m_cmd && m_off <= W) m_rx_bits[m_off-1] = sdi;
        if (abort && m_off < m_last) m_active = 0;
        else if (m_off == m_last) begin
          m_active = 0;
          if (m_cmd) begin m_rx_data = m_rx_bits; m_rx_valid = 1; end
        end else m_off++;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic e_en, e_ld, e_sin, e_txv, e_busy, e_done;
    logic [1:0] e_mode;
    logic [W-1:0] e_pin;
    e_en = 0; e_ld = 0; e_sin = 0; e_txv = 0; e_busy = m_active; e_done = 0;
    e_mode = 2'b11; e_pin = '0;
    if (m_active) begin
      if (!m_cmd) begin
        if (m_off == 1) begin e_en = 1; e_ld = 1; e_mode = 2'b10; e_pin = m_data; end
        else if (m_off <= W + 1) begin e_en = 1; e_mode = 2'b10; e_txv = 1; end
        else e_done = 1;
      end else begin
        if (m_off <= W) begin e_en = 1; e_mode = 2'b00; e_sin = sdi; end
        else e_done = 1;
      end
    end
    chk("s_ready", s_ready, !e_busy);
    chk("busy", busy, e_busy);
    chk("reg_enable", reg_enable, e_en);
    chk("reg_load", reg_load, e_ld);
    chk("reg_mode", reg_mode, e_mode);
    chk("reg_parallel_in", reg_parallel_in, e_pin);
    chk("reg_serial_in", reg_serial_in, e_sin);
    chk("tx_bit_valid", tx_bit_valid, e_txv);
    chk("done", done, e_done);
    chk("rx_valid", rx_valid, m_rx_valid);
    chk("rx_data", rx_data, m_rx_data);
    if (e_txv) chk("serial_out", stub_q[0], m_data[m_off-2]);
  end

  // Event recorder for the hand-computed literal checks
  int           cyc = 0;
  int           acc_n, load_n, done_n, rxv_n, txn, t_rdy, t_rxv;
  int           acc_t[4];
  int           done_t[4];
  logic [W-1:0] tx_word;
  bit           prev_ready = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_valid && s_ready) begin if (acc_n < 4) acc_t[acc_n] = cyc; acc_n++; end
    if (reg_load) load_n++;
    if (done) begin if (done_n < 4) done_t[done_n] = cyc; done_n++; end
    if (rx_valid) begin rxv_n++; t_rxv = cyc; end
    if (tx_bit_valid) begin if (txn < W) tx_word[txn] = stub_q[0]; txn++; end
    if (s_ready && !prev_ready) t_rdy = cyc;
    prev_ready = s_ready;
  end

  task automatic clear_stats();
    acc_n = 0; load_n = 0; done_n = 0; rxv_n = 0; txn = 0;
    t_rdy = -1; t_rxv = -1; tx_word = '0;
    for (int i = 0; i < 4; i++) begin acc_t[i] = -1; done_t[i] = -1; end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  localparam logic [W-1:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [W-1:0] PA5 = {16{8'hA5}};
  localparam logic [W-1:0] P3 = 128'hDEAD_BEEF_0F1E_2D3C_4B5A_6978_8796_A5B4;
  localparam logic [W-1:0] D4 = 128'h8000_0000_0000_0001_FFFF_0000_C3C3_3C3C;
  localparam logic [W-1:0] D5 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [W-1:0] D6 = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_BEEF;

  initial begin
    logic [W-1:0] pat;
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    chk("rst s_ready", s_ready, 1'b1);
    chk("rst reg_mode", reg_mode, 2'b11);
    chk("rst busy", busy, 1'b0);
    chk("rst rx_data", rx_data, '0);
    step(); rst = 1'b1;
    repeat (2) step();

    // 1: TX
    clear_stats();
    s_valid = 1; s_cmd = 0; s_data = D1;
    step(); s_valid = 0; s_data = '0;
    repeat (135) step();
    chk("t1 load cycles", load_n, 1);
    chk("t1 tx bits", txn, 128);
    chk("t1 tx word", tx_word, D1);
    chk("t1 done latency", done_t[0] - acc_t[0], 130);
    chk("t1 ready latency", t_rdy - acc_t[0], 131);
    chk("t1 done count", done_n, 1);

    // 2: RX of A5 pattern
    clear_stats();
    pat = PA5;
    s_valid = 1; s_cmd = 1;
    step(); s_valid = 0;
    for (int k = 0; k < W; k++) begin sdi = pat[k]; step(); end
    sdi = 0;
    repeat (5) step();
    chk("t2 rx_valid latency", t_rxv - acc_t[0], 130);
    chk("t2 rx_data", rx_data, PA5);
    chk("t2 done count", done_n, 1);
    chk("t2 rx_valid count", rxv_n, 1);

    // 3: TX then RX with s_valid held
    clear_stats();
    pat = P3;
    s_valid = 1; s_cmd = 0; s_data = D1;
    step(); s_cmd = 1;
    repeat (130) step();
    step(); s_valid = 0;
    for (int k = 0; k < W; k++) begin sdi = pat[k]; step(); end
    sdi = 0;
    repeat (5) step();
    chk("t3 second accept gap", acc_t[1] - acc_t[0], 131);
    chk("t3 first done", done_t[0] - acc_t[0], 130);
    chk("t3 second done", done_t[1] - acc_t[1], 129);
    chk("t3 rx_data", rx_data, P3);
    chk("t3 accept count", acc_n, 2);

    // 4: abort RX at counter 5, then TX straight away
    clear_stats();
    s_valid = 1; s_cmd = 1;
    step(); s_valid = 0;
    for (int k = 0; k < 6; k++) begin
      sdi = k[0];
      abort = (k == 5);
      step();
    end
    abort = 0; sdi = 0;
    chk("t4 enable after abort", reg_enable, 1'b0);
    chk("t4 ready after abort", s_ready, 1'b1);
    s_valid = 1; s_cmd = 0; s_data = D4;
    step(); s_valid = 0;
    repeat (135) step();
    chk("t4 done count", done_n, 1);
    chk("t4 rx_valid count", rxv_n, 0);
    chk("t4 rx_data kept", rx_data, P3);
    chk("t4 tx word", tx_word, D4);

    // 5: reset during TX shift (counter 60), then full TX
    clear_stats();
    s_valid = 1; s_cmd = 0; s_data = D1;
    step(); s_valid = 0;
    repeat (61) step();
    #2; rst = 0; #1;
    chk("t5 busy in reset", busy, 1'b0);
    chk("t5 s_ready in reset", s_ready, 1'b1);
    chk("t5 enable in reset", reg_enable, 1'b0);
    chk("t5 mode in reset", reg_mode, 2'b11);
    chk("t5 tx_bit_valid in reset", tx_bit_valid, 1'b0);
    chk("t5 rx_data in reset", rx_data, '0);
    step(); rst = 1;
    step();
    chk("t5 no done", done_n, 0);
    clear_stats();
    s_valid = 1; s_cmd = 0; s_data = D5;
    step(); s_valid = 0;
    repeat (135) step();
    chk("t5 tx word", tx_word, D5);
    chk("t5 done count", done_n, 1);

    // 6: s_valid held while busy with different data
    clear_stats();
    s_valid = 1; s_cmd = 0; s_data = D6;
    step(); s_data = ~D6;
    repeat (129) step();
    s_valid = 0;
    repeat (5) step();
    chk("t6 accept count", acc_n, 1);
    chk("t6 tx word", tx_word, D6);
    chk("t6 done count", done_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
- Control stage directly upstream of the TMR 128-bit shift register (three register copies plus a voter).
- Drives the register's `enable`, `load`, `mode`, `parallel_in` and `serial_in` from a valid/ready command interface.
- Transmit (PISO) and receive (SIPO) command types.
- Counts shift cycles and reports completion.
- Returns received words captured from the voted `parallel_out`.

Parameters:
- `width`, 128, register width in bits; must match the downstream register; min 2.
- `cw`, $clog2(width+1), bit-counter width; derived, not overridden.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous active-low reset.
- `s_valid` input 1: command valid.
- `s_ready` output 1: sequencer can accept a command.
- `s_cmd` input 1: 0 = TX (PISO), 1 = RX (SIPO).
- `s_data` input width: TX word; ignored for RX.
- `abort` input 1: synchronous cancel of the active command.
- `sdi` input 1: serial line input for RX.
- `reg_enable` output 1: to register `enable`.
- `reg_load` output 1: to register `load`.
- `reg_mode` output 2: to register `mode`.
- `reg_parallel_in` output width: to register `parallel_in`.
- `reg_serial_in` output 1: to register `serial_in`.
- `reg_parallel_out` input width: voted `parallel_out` from the register.
- `tx_bit_valid` output 1: voted `serial_out` carries a valid TX bit this cycle.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle completion pulse.
- `rx_valid` output 1: one-cycle pulse, `rx_data` updated.
- `rx_data` output width: last received word.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is asynchronous, active-low.
  - Reset: state IDLE, counter 0, `data_q` 0, `cmd_q` 0, `rx_data` 0.
  - Reset outputs: `s_ready` 1, `reg_enable` 0, `reg_load` 0, `reg_mode` 2'b11, `reg_parallel_in` 0, `reg_serial_in` 0, `tx_bit_valid` 0, `busy` 0, `done` 0, `rx_valid` 0.
- States: IDLE, LOAD, SHIFT, DONE; state and counter registered.
- IDLE:
  - `s_ready`=1, `reg_enable`=0, `reg_mode`=2'b11, `reg_load`=0; the register holds.
  - `s_valid`&&`s_ready` latches `s_cmd` and `s_data` into `cmd_q`/`data_q`.
  - TX goes to LOAD; RX goes to SHIFT; counter cleared.
- LOAD (TX only, 1 cycle): `reg_mode`=2'b10, `reg_load`=1, `reg_enable`=1, `reg_parallel_in`=`data_q`; next state SHIFT.
- SHIFT, exactly `width` cycles, counter increments each cycle, exits to DONE when counter==width-1:
  - TX: `reg_mode`=2'b10, `reg_load`=0, `reg_enable`=1, `tx_bit_valid`=1.
  - TX line order: during the k-th SHIFT cycle (k=0..width-1) the register `serial_out` equals `data_q[k]`, LSB first.
  - RX: `reg_mode`=2'b00, `reg_enable`=1, `reg_serial_in`=`sdi` (combinational passthrough).
  - RX bit order: the `sdi` bit of the first SHIFT cycle ends at bit 0, the last at bit width-1.
- DONE (1 cycle):
  - `done`=1, `reg_enable`=0, `reg_mode`=2'b11; next state IDLE.
  - If `cmd_q`=RX, `rx_data`<=`reg_parallel_out` at the DONE exit edge and `rx_valid`=1 in the following cycle only.
- `busy`=1 in LOAD, SHIFT, DONE; `s_ready`=!`busy`.
- `reg_parallel_in` is driven with `data_q` only in LOAD, 0 otherwise.
- Latency, TX accepted at cycle T:
  - LOAD at T+1; SHIFT T+2..T+width+1; DONE T+width+2; `s_ready` again at T+width+3.
- Latency, RX accepted at cycle T:
  - SHIFT T+1..T+width; DONE T+width+1; `rx_valid` at T+width+2.
- Abort and back-to-back:
  - `abort` in LOAD or SHIFT: next state IDLE, no `done`, no `rx_valid`, register contents left as-is.
  - `abort` in IDLE or DONE is ignored.
  - A new command may be accepted in the same cycle `rx_valid` is high; `rx_data` is not disturbed until the next RX DONE.
- Reset mid-operation: immediate return to reset values; no pulse is generated.
- `s_data` and `s_cmd` are don't-care when no handshake occurs.

Test Plan:
1. Reset, then TX `s_data`=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> `reg_load` high for exactly 1 cycle; 128 `tx_bit_valid` cycles; `serial_out` sequence equals `s_data` LSB first; `done` at T+130; `s_ready` at T+131.
2. RX with `sdi` = bits of 128'hA5A5...A5 LSB first -> `rx_valid` pulse at T+130; `rx_data`=128'hA5A5...A5; `done` exactly once.
3. TX then RX back-to-back with `s_valid` held -> second accept on the first `s_ready` cycle after DONE; no gap in `done` pulses other than specified latency; `reg_mode` 10 then 11 then 00.
4. Abort at SHIFT counter=5 in RX -> IDLE next cycle, `reg_enable` 0, no `done`/`rx_valid`, `rx_data` keeps its previous value; new TX accepted immediately.
5. `rst` low at SHIFT counter=60 -> all outputs at reset values asynchronously; after release, a full TX completes correctly.
6. `s_valid`=1 while busy -> no accept, `data_q` unchanged; verify `s_ready`=0 in LOAD/SHIFT/DONE.
